// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared FSM states and byte-order constants for the bank dump engine
//
// Purpose: types and constants shared by mem_dump and the program loader.
// Ports: none (package).
package mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    OUT,
    CKS,
    FIN
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Byte emit order within a word, first slot in the top two bits: 3,2,1,0.
  // The loader stores file byte i+3 at bank[i], so walking 3..0 restores file order.
  localparam logic [7:0] BYTE_ORDER     = 8'b11_10_01_00;
  localparam logic [1:0] FIRST_BYTE_IDX = BYTE_ORDER[7:6];
  localparam logic [1:0] LAST_BYTE_IDX  = BYTE_ORDER[1:0];

endpackage

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - streams a word-aligned range of a byte-wide bank out as raw.out-ordered bytes
//
// Purpose: debug/readback master on the cache spare read port. For each word a it
//   emits bank[a+3], bank[a+2], bank[a+1], bank[a] over a valid/ready byte port.
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   start, base_addr,     - request: single-cycle start, 4-aligned byte address,
//   word_count              number of 32-bit words
//   busy, done, err       - status: busy while transferring, done pulse, err pulse on reject
//   mem_rd_en, mem_addr,  - bank read port; mem_rdata is valid one cycle after mem_rd_en
//   mem_rdata
//   out_valid, out_data,  - byte stream; a byte moves when out_valid && out_ready
//   out_ready
// Configuration: define MEM_DUMP_CKSUM_EN to append an 8-bit running sum byte
//   after the last data byte of a non-empty accepted request.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES_PER_WORD);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
`ifdef MEM_DUMP_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    byte_idx_d  = byte_idx_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef MEM_DUMP_CKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          if (base_addr[1:0] != 2'b00) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (word_count == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            word_addr_d = base_addr;
            cnt_d       = word_count;
            byte_idx_d  = FIRST_BYTE_IDX;
            state_d     = RD;
`ifdef MEM_DUMP_CKSUM_EN
            sum_d       = 8'h00;
`endif
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef MEM_DUMP_CKSUM_EN
          sum_d       = sum_q + out_data_q;
`endif
          if (byte_idx_q != LAST_BYTE_IDX) begin
            byte_idx_d = byte_idx_q - 2'd1;
            state_d    = RD;
          end else if (cnt_q > CNT_W'(1)) begin
            // Address wraps modulo the bank size on purpose.
            word_addr_d = word_addr_q + WORD_STEP;
            byte_idx_d  = FIRST_BYTE_IDX;
            cnt_d       = cnt_q - CNT_W'(1);
            state_d     = RD;
          end else begin
`ifdef MEM_DUMP_CKSUM_EN
            state_d     = CKS;
            out_valid_d = 1'b1;
            out_data_d  = sum_q + out_data_q;
`else
            state_d     = FIN;
            done_d      = 1'b1;
`endif
          end
        end
      end
`ifdef MEM_DUMP_CKSUM_EN
      CKS: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FIN;
          done_d      = 1'b1;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read strobe and address are registered on entry to RD, so the address only moves there.
    rd_en_d    = (state_d == RD);
    mem_addr_d = (state_d == RD) ? (word_addr_d + ADDR_W'(byte_idx_d)) : mem_addr_q;
    // A rejected or empty request passes through FIN without ever raising busy.
    busy_d     = (state_d != IDLE) && !((state_q == IDLE) && (state_d == FIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      mem_addr_q  <= '0;
      byte_idx_q  <= 2'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
`ifdef MEM_DUMP_CKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      mem_addr_q  <= mem_addr_d;
      byte_idx_q  <= byte_idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef MEM_DUMP_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/mem_dump.md
Name: mem_dump

Overview:
- Reads a word-aligned range out of a byte-wide memory bank (data or instruction cache array) and streams it out as bytes over a valid/ready port.
- This is the reverse of the program loader. The loader places file byte i+3 at bank[i] and file byte i+0 at bank[i+3].
- The dump emits bank[a+3], bank[a+2], bank[a+1], bank[a] for each word a. The output stream is therefore byte-identical to the raw.out file format and can be diffed directly.
- Sits beside control as a debug/readback master on the cache's spare read port.

Parameters:
- ADDR_W, 12, byte-address width of the memory bank (4096 bytes).
- CNT_W, 11, width of word_count; must equal ADDR_W-1 so the full bank can be dumped.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of first word; must be 4-aligned.
- word_count  in  CNT_W  number of 32-bit words to dump.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of request.
- err  out  1  one-cycle pulse coincident with done when request rejected.
- mem_rd_en  out  1  read strobe to bank.
- mem_addr  out  ADDR_W  byte address to bank.
- mem_rdata  in  8  bank read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  out_data valid.
- out_data  out  8  streamed byte.
- out_ready  in  1  sink accepts byte when out_valid && out_ready.

Behaviour:
- Reset values: busy, done, err, mem_rd_en, out_valid = 0; mem_addr, out_data = 0; FSM = IDLE. Internal word address, byte index (0..3) and word counter are also cleared.
- FSM states: IDLE, RD, CAP, OUT, FIN.
- IDLE:
  - start=1 with base_addr[1:0]!=0 → FIN with err flag set.
  - start=1 with word_count==0 → FIN, no err.
  - Otherwise latch base_addr, latch word_count, set byte index=3, go to RD.
- RD: mem_rd_en=1, mem_addr = word_addr + byte_index. Next state is CAP.
- CAP: capture mem_rdata into out_data, set out_valid=1, go to OUT.
- OUT:
  - Hold out_valid and out_data stable until out_ready.
  - On handshake, clear out_valid.
  - If byte_index>0: decrement byte_index, go to RD.
  - Else if words remaining>1: word_addr += 4, byte_index=3, decrement counter, go to RD.
  - Else go to FIN.
- FIN: done=1 for one cycle (err=1 if flagged), busy=0 in the following cycle, then IDLE.
- Throughput: 3 cycles per byte with out_ready held high.
  - First out_valid appears 3 cycles after start is sampled.
  - done is asserted 1 cycle after the final handshake.
- Addressing:
  - word_addr arithmetic is modulo 2^ADDR_W; a range running past the top wraps to 0 silently.
  - mem_addr only changes in RD.
- start while busy is ignored; it is not queued.
- out_ready stalls may be arbitrarily long. No memory read is issued while a byte is pending.
- Reset mid-transfer: all outputs return to reset values immediately (async) and the partial stream is abandoned. The sink must discard a partial stream.
- mem_rd_en is never asserted outside RD.

Optional Feature:
- Macro MEM_DUMP_CKSUM_EN.
- When defined:
  - Maintain an 8-bit running sum (mod 256) of every data byte handshaken, cleared on accepted start.
  - After the last data byte, OUT transitions to a CKS state that presents the sum as one extra out_valid byte. FIN follows its handshake.
  - Rejected or zero-length requests emit no checksum.
- When undefined: no CKS state and no extra byte; the stream is exactly 4*word_count bytes.

Decomposition:
- Package mem_dump_pkg:
  - FSM state enum (IDLE, RD, CAP, OUT, CKS, FIN).
  - BYTES_PER_WORD=4.
  - Byte-order constant describing the descending index 3..0 emit order, shared with the loader.
- No sub-module is needed. The output byte register with its hold logic is small enough to stay inline.

Test Plan:
- bank[4..11] = 00 00 00 0A 00 00 00 0B; start, base=4, count=2, out_ready=1 → bytes 0A 00 00 00 0B 00 00 00, mem_addr sequence 7,6,5,4,11,10,9,8, one done, err=0.
- Same request with out_ready toggled 0/1 at random, including 20-cycle stalls → identical byte stream, out_data stable while out_valid && !out_ready.
- start base=6 → done and err pulse together, no mem_rd_en, no out_valid; start with count=0 → done, err=0, no output.
- base=4092, count=2, bank[4092..4095]=11 22 33 44, bank[0..3]=AA BB CC DD → 44 33 22 11 DD CC BB AA (wrap).
- rst_n low during 2nd word → outputs zero asynchronously; a new start after release dumps correctly from scratch.
- With MEM_DUMP_CKSUM_EN, first scenario → 9th byte = 0x15; without it → exactly 8 bytes then done.
